uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART link. It synchronises rxd, detects start bits, and schedules mid-bit sampling at a runtime-programmable clocks-per-bit divisor. It assembles an 11-bit frame (start, 8 data LSB-first, optional parity, stop), checks it, and hands each byte downstream over a valid/ready handshake with overrun protection.

---
 rtl/uart_rx_ctrl.sv | 112 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver with parity/stop checking and valid/ready byte delivery
module uart_rx_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] n,
  input  logic             rxd,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [10:0]      frame,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  state_t state, state_n;
  logic rxd_m, rxd_s;
  logic [DIV_W-1:0] cnt, cnt_inc, n_l, half;
  logic [2:0] bit_idx;
  logic [7:0] data;
  logic pe_l, po_l, par_bit, stop_bit, done, adv, tick, load;
  assign cnt_inc = cnt + 1'b1;
  assign half = n_l >> 1;
  assign tick = cnt == n_l - 1'b1;
  assign load = done & (~out_valid | out_ready);
  assign busy = state != IDLE;
  // two-flop synchroniser for the asynchronous serial line, idling high
  always_ff @(posedge clk or posedge rst)
    if (rst) {rxd_m, rxd_s} <= 2'b11;
    else {rxd_m, rxd_s} <= {rxd, rxd_m};
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and sample strobe: adv marks the clock on which rxd_s is sampled
  always_comb begin
    state_n = state;
    adv = 1'b0;
    case (state)
      IDLE: state_n = rxd_s ? IDLE : START;
      START: begin
        adv = cnt_inc == half;
        if (adv) state_n = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        adv = tick;
        if (adv && bit_idx == 3'd7) state_n = pe_l ? PARITY : STOP;
      end
      PARITY: begin
        adv = tick;
        if (adv) state_n = STOP;
      end
      STOP: begin
        adv = tick;
        if (adv) state_n = rxd_s ? IDLE : BRK_WAIT;
      end
      BRK_WAIT: state_n = rxd_s ? IDLE : BRK_WAIT;
      default: state_n = IDLE;
    endcase
  end
  // bit timing, per-frame configuration latch and frame assembly
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      bit_idx <= '0;
      n_l <= '0;
      pe_l <= 1'b0;
      po_l <= 1'b0;
      data <= '0;
      par_bit <= 1'b0;
      stop_bit <= 1'b0;
      done <= 1'b0;
    end else begin
      cnt <= (state == IDLE || state == BRK_WAIT || adv) ? '0 : cnt_inc;
      bit_idx <= state != DATA ? 3'd0 : bit_idx + 3'(adv);
      if (state == IDLE) begin
        n_l <= n < DIV_W'(2) ? DIV_W'(2) : n;
        pe_l <= parity_en;
        po_l <= parity_odd;
        par_bit <= 1'b0;
      end
      if (state == DATA && adv) data[bit_idx] <= rxd_s;
      if (state == PARITY && adv) par_bit <= rxd_s;
      if (state == STOP && adv) stop_bit <= rxd_s;
      done <= state == STOP && adv;
    end
  // downstream handshake: load when the holding register is free or draining, else flag overrun
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      frame <= '0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      out_valid <= load | (out_valid & ~out_ready);
      overrun <= (done & ~load) | (overrun & ~clr_err);
      if (load) begin
        out_data <= data;
        frame <= {stop_bit, par_bit, data, 1'b0};
        parity_err <= pe_l & (po_l ? ~^{data, par_bit} : ^{data, par_bit});
        frame_err <= ~stop_bit;
      end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: vector table, hand-built corner sequences and randomized frames against a byte-level model
module tb_uart_rx_ctrl;
  localparam int DIV_W = 8;
  logic clk = 1'b0, rst = 1'b0;
  logic [DIV_W-1:0] n = 8'd8;
  logic rxd = 1'b1, parity_en = 1'b0, parity_odd = 1'b0, out_ready = 1'b1, clr_err = 1'b0;
  logic out_valid, parity_err, frame_err, overrun, busy;
  logic [7:0] out_data;
  logic [10:0] frame;
  typedef struct {
    logic [7:0] d;
    logic [10:0] f;
    logic perr;
    logic ferr;
  } rec_t;
  typedef struct {
    logic [7:0] d;
    int nn;
    logic pe, po, p, stp;
    logic [10:0] ef;
    logic eperr, eferr;
  } vec_t;
  rec_t got_q[$], exp_q[$];
  rec_t cap;
  vec_t vt[8];
  int checks = 0, errors = 0;
  bit rnd_rdy = 1'b0;
  always #5 clk = ~clk;
  uart_rx_ctrl #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .n(n), .rxd(rxd), .parity_en(parity_en), .parity_odd(parity_odd),
    .out_ready(out_ready), .clr_err(clr_err), .out_valid(out_valid), .out_data(out_data),
    .frame(frame), .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  // record every completed transfer, sampled mid-cycle
  always @(negedge clk)
    if (out_valid && out_ready) begin
      cap = '{out_data, frame, parity_err, frame_err};
      got_q.push_back(cap);
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic check_rec(input string tag, input rec_t a, input rec_t e);
    chk({tag, "_data"}, 32'(a.d), 32'(e.d));
    chk({tag, "_frame"}, 32'(a.f), 32'(e.f));
    chk({tag, "_perr"}, 32'(a.perr), 32'(e.perr));
    chk({tag, "_ferr"}, 32'(a.ferr), 32'(e.ferr));
  endtask
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  endtask
  function automatic rec_t model(input logic [7:0] d, input logic pe, po, p, stp);
    rec_t r;
    r.d = d;
    r.f = {stp, pe ? p : 1'b0, d, 1'b0};
    r.perr = pe && ((($countones(d) + int'(p)) % 2) == (po ? 0 : 1));
    r.ferr = ~stp;
    return r;
  endfunction
  task automatic send(input logic [7:0] d, input int nn, input logic pe, po, p, stp, input int wob);
    int per;
    logic b[$];
    per = nn < 2 ? 2 : nn;
    n = DIV_W'(nn);
    parity_en = pe;
    parity_odd = po;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pe) b.push_back(p);
    b.push_back(stp);
    foreach (b[i]) begin
      rxd = b[i];
      cyc(per);
      if (i == 1 && wob != 0) begin
        n = DIV_W'(wob);
        parity_en = ~pe;
        parity_odd = ~po;
      end
    end
    rxd = 1'b1;
    cyc(2 * per);
  endtask
  initial begin
    int b0, b1, nn;
    logic [7:0] d;
    logic pe, po, p, stp;
    rec_t e;
    vt[0] = '{8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 11'h54A, 1'b0, 1'b0};
    vt[1] = '{8'h03, 8, 1'b1, 1'b0, 1'b1, 1'b1, 11'h606, 1'b1, 1'b0};
    vt[2] = '{8'h03, 8, 1'b1, 1'b0, 1'b0, 1'b1, 11'h406, 1'b0, 1'b0};
    vt[3] = '{8'h03, 8, 1'b1, 1'b1, 1'b1, 1'b1, 11'h606, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 3, 1'b0, 1'b0, 1'b0, 1'b1, 11'h5FE, 1'b0, 1'b0};
    vt[5] = '{8'h00, 5, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b1};
    vt[6] = '{8'h3C, 1, 1'b1, 1'b1, 1'b1, 1'b1, 11'h678, 1'b0, 1'b0};
    vt[7] = '{8'hC4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h188, 1'b1, 1'b1};
    #1 rst = 1'b1;
    cyc(3);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_frame", 32'(frame), 0);
    chk("rst_flags", 32'({parity_err, frame_err, overrun}), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    cyc(3);
    for (int i = 0; i < 8; i++) begin
      b0 = got_q.size();
      send(vt[i].d, vt[i].nn, vt[i].pe, vt[i].po, vt[i].p, vt[i].stp, 0);
      chk($sformatf("vec%0d_count", i), 32'(got_q.size()), 32'(b0 + 1));
      e = '{vt[i].d, vt[i].ef, vt[i].eperr, vt[i].eferr};
      if (got_q.size() > b0) check_rec($sformatf("vec%0d", i), got_q[b0], e);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 0);
    end
    b0 = got_q.size();
    n = 8'd8;
    rxd = 1'b0;
    cyc(2);
    rxd = 1'b1;
    cyc(2);
    chk("false_start_busy_hi", 32'(busy), 1);
    cyc(8);
    chk("false_start_busy_lo", 32'(busy), 0);
    chk("false_start_valid", 32'(out_valid), 0);
    chk("false_start_count", 32'(got_q.size()), 32'(b0));
    out_ready = 1'b0;
    b0 = got_q.size();
    send(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("ovr_valid", 32'(out_valid), 1);
    chk("ovr_data", 32'(out_data), 32'h11);
    chk("ovr_flag", 32'(overrun), 1);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    chk("ovr_cleared", 32'(overrun), 0);
    chk("ovr_still_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    cyc(10);
    chk("ovr_xfer_count", 32'(got_q.size()), 32'(b0 + 1));
    if (got_q.size() > b0) chk("ovr_xfer_data", 32'(got_q[b0].d), 32'h11);
    chk("ovr_valid_drop", 32'(out_valid), 0);
    n = 8'd4;
    b0 = got_q.size();
    rxd = 1'b0;
    cyc(160);
    chk("brk_count", 32'(got_q.size()), 32'(b0 + 1));
    if (got_q.size() > b0) begin
      chk("brk_data", 32'(got_q[b0].d), 0);
      chk("brk_ferr", 32'(got_q[b0].ferr), 1);
      chk("brk_stop", 32'(got_q[b0].f[10]), 0);
    end
    chk("brk_busy", 32'(busy), 1);
    rxd = 1'b1;
    cyc(20);
    chk("brk_no_retrigger", 32'(got_q.size()), 32'(b0 + 1));
    chk("brk_idle", 32'(busy), 0);
    b0 = got_q.size();
    send(8'h81, 4, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("post_brk_count", 32'(got_q.size()), 32'(b0 + 1));
    if (got_q.size() > b0) chk("post_brk_data", 32'(got_q[b0].d), 32'h81);
    out_ready = 1'b0;
    send(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("pre_rst_valid", 32'(out_valid), 1);
    b1 = got_q.size();
    fork
      send(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      begin
        cyc(40);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", 32'(out_data), 0);
        chk("async_rst_frame", 32'(frame), 0);
        chk("async_rst_busy", 32'(busy), 0);
      end
    join
    out_ready = 1'b1;
    rst = 1'b0;
    cyc(4);
    chk("no_partial_byte", 32'(got_q.size()), 32'(b1));
    b0 = got_q.size();
    send(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("post_rst_count", 32'(got_q.size()), 32'(b0 + 1));
    if (got_q.size() > b0) chk("post_rst_data", 32'(got_q[b0].d), 32'h5A);
    b0 = got_q.size();
    send(8'hC3, 8, 1'b1, 1'b0, 1'b0, 1'b1, 5);
    chk("nchg_count", 32'(got_q.size()), 32'(b0 + 1));
    if (got_q.size() > b0) check_rec("nchg", got_q[b0], model(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1));
    got_q.delete();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int w = 0; w < 300 && out_valid; w++) cyc(1);
      chk($sformatf("rnd%0d_drain", i), 32'(out_valid), 0);
      d = 8'($urandom);
      nn = $urandom_range(0, 12);
      pe = 1'($urandom);
      po = 1'($urandom);
      p = 1'($urandom);
      stp = $urandom_range(0, 7) != 0;
      exp_q.push_back(model(d, pe, po, p, stp));
      send(d, nn, pe, po, p, stp, $urandom_range(2, 12));
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    cyc(20);
    chk("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_q.size()) check_rec($sformatf("rnd%0d", i), got_q[i], exp_q[i]);
    chk("rnd_overrun", 32'(overrun), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
